// File: rtl/piano_pkg.sv
// Shared constants and types for the piano song path (player, library, recorder).
package piano_pkg;

   localparam int unsigned NOTE_W    = 4;
   localparam int unsigned DUR_W     = 26;
   localparam int unsigned SONG_LEN  = 24;
   localparam logic [NOTE_W-1:0] REST_NOTE = 4'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      TIMING = 2'd2,
      DONE   = 2'd3
   } rec_state_t;

endpackage

// File: rtl/record_mode_if.sv
// Keyboard capture inputs and song-library-shaped read port of the recorder.
interface record_mode_if
   import piano_pkg::*;
#(
   parameter int unsigned DUR_W = 26
);

   logic                rec_en;
   logic                key_on;
   logic [NOTE_W-1:0]   key;
   logic [4:0]          rd_index;
   logic [NOTE_W-1:0]   rd_note;
   logic [DUR_W-1:0]    rd_duration;
   logic [4:0]          note_count;
   logic                recording;
   logic                full;

   modport master (
      output rec_en, key_on, key, rd_index,
      input  rd_note, rd_duration, note_count, recording, full
   );

   modport slave (
      input  rec_en, key_on, key, rd_index,
      output rd_note, rd_duration, note_count, recording, full
   );

endinterface

// File: rtl/record_buffer.sv
// Note/duration register file: synchronous write, combinational read, no reset on storage.
module record_buffer
   import piano_pkg::*;
#(
   parameter int unsigned DEPTH = 24,
   parameter int unsigned W     = 30
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [4:0]    i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [4:0]    i_raddr,
   output logic [W-1:0]  o_rdata
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we && (int'(i_waddr) < DEPTH))
         r_mem[i_waddr[AW-1:0]] <= i_wdata;
   end

   always_comb begin
      o_rdata = '0;
      if (int'(i_raddr) < DEPTH)
         o_rdata = r_mem[i_raddr[AW-1:0]];
   end

endmodule

// File: rtl/record_mode.sv
// Records key presses as {note, duration} entries for later replay by the song player.
module record_mode
   import piano_pkg::*;
#(
   parameter int unsigned        DEPTH   = SONG_LEN,
   parameter int unsigned        DUR_W   = 26,
   parameter logic [DUR_W-1:0]   MAX_DUR = '1
)(
   input  logic         clk,
   input  logic         rst_n,
   record_mode_if.slave bus
);

   rec_state_t          r_state, w_state_nxt;
   logic [4:0]          r_wr_ptr, w_wr_ptr_nxt;
   logic [DUR_W-1:0]    r_cnt, w_cnt_nxt;
   logic [NOTE_W-1:0]   r_pend_note, w_pend_nxt;
   logic                r_full, w_full_nxt;
   logic                r_key_on_d, r_rec_en_d;

   logic                w_press, w_chg, w_last, w_we;
   logic [DUR_W-1:0]    w_cnt_inc;
   logic [NOTE_W+DUR_W-1:0] w_wdata, w_rdata;

   assign w_press   = bus.key_on & ~r_key_on_d;
   assign w_chg     = bus.key_on & r_key_on_d & (bus.key != r_pend_note);
   assign w_last    = (r_wr_ptr == 5'(DEPTH - 1));
   assign w_cnt_inc = (r_cnt >= MAX_DUR) ? MAX_DUR : r_cnt + 1'b1;
   assign w_wdata   = {r_pend_note, r_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
         r_pend_note <= REST_NOTE;
         r_full      <= 1'b0;
         r_key_on_d  <= 1'b0;
         r_rec_en_d  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pend_note <= w_pend_nxt;
         r_full      <= w_full_nxt;
         r_key_on_d  <= bus.key_on;
         r_rec_en_d  <= bus.rec_en;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_ptr_nxt = r_wr_ptr;
      w_cnt_nxt    = r_cnt;
      w_pend_nxt   = r_pend_note;
      w_full_nxt   = r_full;
      w_we         = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.rec_en && !r_rec_en_d) begin
               w_wr_ptr_nxt = '0;
               w_full_nxt   = 1'b0;
               w_state_nxt  = ARMED;
            end
         end
         ARMED: begin
            if (!bus.rec_en) begin
               w_state_nxt = IDLE;
            end else if (w_press) begin
               w_pend_nxt  = bus.key;
               w_cnt_nxt   = DUR_W'(1);
               w_state_nxt = TIMING;
            end
         end
         TIMING: begin
            w_cnt_nxt = w_cnt_inc;
            // rec_en fall wins over a simultaneous press: commit, drop the press
            if (!bus.rec_en) begin
               w_we         = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + 5'd1;
               w_full_nxt   = w_last;
               w_state_nxt  = IDLE;
            end else if (w_press || w_chg) begin
               w_we         = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + 5'd1;
               if (w_last) begin
                  w_full_nxt  = 1'b1;
                  w_state_nxt = DONE;
               end else begin
                  w_pend_nxt = bus.key;
                  w_cnt_nxt  = DUR_W'(1);
               end
            end
         end
         DONE: begin
            if (!bus.rec_en)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   record_buffer #(
      .DEPTH (DEPTH),
      .W     (NOTE_W + DUR_W)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (bus.rd_index),
      .o_rdata (w_rdata)
   );

   always_comb begin
      bus.rd_note     = REST_NOTE;
      bus.rd_duration = '0;
      if (bus.rd_index < r_wr_ptr) begin
         bus.rd_note     = w_rdata[NOTE_W+DUR_W-1:DUR_W];
         bus.rd_duration = w_rdata[DUR_W-1:0];
      end
   end

   assign bus.note_count = r_wr_ptr;
   assign bus.recording  = (r_state == ARMED) || (r_state == TIMING);
   assign bus.full       = r_full;

endmodule

// File: tb/tb_record_mode.sv
// Directed bench for record_mode with DEPTH=4 and MAX_DUR=100.
module tb_record_mode;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   record_mode_if #(.DUR_W(26)) bus ();

   record_mode #(
      .DEPTH   (4),
      .DUR_W   (26),
      .MAX_DUR (26'd100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_entry(input string tag, input logic [4:0] idx,
                            input logic [3:0] note, input logic [25:0] dur);
      bus.rd_index = idx;
      #1;
      chk({tag, ".note"}, 32'(bus.rd_note), 32'(note));
      chk({tag, ".dur"},  32'(bus.rd_duration), 32'(dur));
   endtask

   initial begin
      bus.rec_en   = 1'b0;
      bus.key_on   = 1'b0;
      bus.key      = 4'd0;
      bus.rd_index = 5'd0;

      // reset asserted before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("rst.count", 32'(bus.note_count), 0);
      chk("rst.recording", 32'(bus.recording), 0);
      chk("rst.full", 32'(bus.full), 0);
      chk("rst.rd_note", 32'(bus.rd_note), 0);
      chk("rst.rd_dur", 32'(bus.rd_duration), 0);
      #10 rst_n = 1'b1;
      tick(2);

      // basic take: key 3 pressed E0, released E10, key 5 pressed E20, rec_en low E50
      bus.rec_en = 1'b1;
      tick();
      chk("basic.armed", 32'(bus.recording), 1);
      bus.key = 4'd3; bus.key_on = 1'b1;
      tick();                                  // E0
      tick(9);
      bus.key_on = 1'b0;
      tick();                                  // E10
      tick(9);
      bus.key = 4'd5; bus.key_on = 1'b1;
      tick();                                  // E20
      chk("basic.count1", 32'(bus.note_count), 1);
      chk_entry("basic.e0_early", 5'd0, 4'd3, 26'd20);
      tick(29);
      bus.rec_en = 1'b0;
      tick();                                  // E50
      chk("basic.count2", 32'(bus.note_count), 2);
      chk("basic.rec_off", 32'(bus.recording), 0);
      chk_entry("basic.e0", 5'd0, 4'd3, 26'd20);
      chk_entry("basic.e1", 5'd1, 4'd5, 26'd30);
      chk_entry("basic.e2_empty", 5'd2, 4'd0, 26'd0);
      bus.key_on = 1'b0;
      tick(2);

      // key change while held: 3 at E0, 7 at E8, rec_en low at E12
      bus.rec_en = 1'b1;
      tick();
      chk("chg.count0", 32'(bus.note_count), 0);
      bus.key = 4'd3; bus.key_on = 1'b1;
      tick();                                  // E0
      tick(7);
      bus.key = 4'd7;
      tick();                                  // E8
      tick(3);
      bus.rec_en = 1'b0;
      tick();                                  // E12
      chk("chg.count", 32'(bus.note_count), 2);
      chk_entry("chg.e0", 5'd0, 4'd3, 26'd8);
      chk_entry("chg.e1", 5'd1, 4'd7, 26'd4);
      bus.key_on = 1'b0;
      tick(2);

      // saturation at MAX_DUR=100 with a 150-cycle hold
      bus.rec_en = 1'b1;
      tick();
      bus.key = 4'd9; bus.key_on = 1'b1;
      tick();
      tick(149);
      bus.rec_en = 1'b0;
      tick();
      chk("sat.count", 32'(bus.note_count), 1);
      chk_entry("sat.e0", 5'd0, 4'd9, 26'd100);
      bus.key_on = 1'b0;
      tick(2);

      // full: six presses 10 cycles apart into a 4-entry buffer
      bus.rec_en = 1'b1;
      tick();
      for (int p = 1; p <= 6; p++) begin
         bus.key = 4'(p); bus.key_on = 1'b1;
         tick();
         if (p == 5) begin
            chk("full.flag5", 32'(bus.full), 1);
            chk("full.rec5", 32'(bus.recording), 0);
            chk("full.count5", 32'(bus.note_count), 4);
         end
         tick(4);
         bus.key_on = 1'b0;
         tick(5);
      end
      chk("full.count6", 32'(bus.note_count), 4);
      chk("full.flag6", 32'(bus.full), 1);
      chk_entry("full.e0", 5'd0, 4'd1, 26'd10);
      chk_entry("full.e3", 5'd3, 4'd4, 26'd10);
      chk_entry("full.e4", 5'd4, 4'd0, 26'd0);
      bus.rec_en = 1'b0;
      tick(2);
      chk("full.sticky", 32'(bus.full), 1);
      chk("full.idle", 32'(bus.recording), 0);

      // new take clears full; two commits then reset mid-take
      bus.rec_en = 1'b1;
      tick();
      chk("rstmid.full_clr", 32'(bus.full), 0);
      bus.key = 4'd2; bus.key_on = 1'b1;
      tick(); tick(4); bus.key_on = 1'b0; tick(5);
      bus.key = 4'd6; bus.key_on = 1'b1;
      tick(); tick(4); bus.key_on = 1'b0; tick(5);
      bus.key = 4'd8; bus.key_on = 1'b1;
      tick();
      chk("rstmid.count2", 32'(bus.note_count), 2);
      chk_entry("rstmid.e1", 5'd1, 4'd6, 26'd10);
      bus.rd_index = 5'd0;
      rst_n = 1'b0;
      #1;
      chk("rstmid.count", 32'(bus.note_count), 0);
      chk("rstmid.recording", 32'(bus.recording), 0);
      chk("rstmid.rd_note", 32'(bus.rd_note), 0);
      bus.rec_en = 1'b0;
      bus.key_on = 1'b0;
      #10 rst_n = 1'b1;
      tick(2);
      bus.rec_en = 1'b1;
      tick();
      chk("rstmid.rearm", 32'(bus.recording), 1);
      bus.key = 4'd11; bus.key_on = 1'b1;
      tick();
      tick(5);
      bus.rec_en = 1'b0;
      tick();
      chk("rstmid.newcount", 32'(bus.note_count), 1);
      chk_entry("rstmid.new_e0", 5'd0, 4'd11, 26'd6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
